sprite_compositor: RTL and testbench

SPRITE_COMPOSITOR -- requirements
Module: sprite_compositor

---
 rtl/sprite_compositor.sv | 184 ++++++++++++++++++
 tb/tb_sprite_compositor.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_compositor.sv
// sprite_compositor: priority compositor for NUM_LAYERS palette sprites over
// a background palette, with per-layer enable/opaque/blink control.
//
// Ports
//   clk, Reset            rising-edge clock, async active-high reset
//   frame_start           one-cycle pulse per frame (drives the blink timer)
//   pix_valid             pixel inputs valid this cycle
//   layer_hit/layer_idx   per-layer coverage and palette index (flattened)
//   bg_idx                background palette index
//   layer_en/opaque/blink static per-layer controls, sampled at stage 2
//   pal_we/bank/addr/data palette write port (bank NUM_LAYERS = background)
//   out_valid, VGA_R/G/B  composited pixel, two clocks after the input
//
// Pipeline: stage 1 registers the pixel inputs (and the blink phase), stage 2
// resolves the colour from the palette registers and registers the result.

// Per-layer lane: activity test and palette lookup for one bank.
// Out-of-range indices look up as black.
module sprite_lane #(
  parameter int IDX_W     = 4,
  parameter int PAL_DEPTH = 16
) (
  input  logic                       i_hit,
  input  logic                       i_en,
  input  logic                       i_opaque,
  input  logic                       i_blink,
  input  logic                       i_phase,
  input  logic [IDX_W-1:0]           i_idx,
  input  logic [PAL_DEPTH-1:0][23:0] i_pal,
  output logic                       o_active,
  output logic [23:0]                o_rgb
);
  localparam logic [IDX_W:0] LP_DEPTH = (IDX_W+1)'(PAL_DEPTH);

  logic w_in_range;
  assign w_in_range = {1'b0, i_idx} < LP_DEPTH;

  always_comb begin
    o_rgb = '0;
    for (int e = 0; e < PAL_DEPTH; e++)
      if (i_idx == IDX_W'(e)) o_rgb = i_pal[e];
  end

  // Index 0 and out-of-range indices are transparent unless the layer is opaque.
  assign o_active = i_hit & i_en & (~i_blink | i_phase) &
                    (i_opaque | ((i_idx != '0) & w_in_range));
endmodule

module sprite_compositor #(
  parameter int NUM_LAYERS   = 8,
  parameter int IDX_W        = 4,
  parameter int PAL_DEPTH    = 16,
  parameter int BLINK_FRAMES = 30,
  localparam int NB          = NUM_LAYERS + 1,
  localparam int BANK_W      = $clog2(NUM_LAYERS + 1)
) (
  input  logic                        clk,
  input  logic                        Reset,
  input  logic                        frame_start,
  input  logic                        pix_valid,
  input  logic [NUM_LAYERS-1:0]       layer_hit,
  input  logic [NUM_LAYERS*IDX_W-1:0] layer_idx,
  input  logic [IDX_W-1:0]            bg_idx,
  input  logic [NUM_LAYERS-1:0]       layer_en,
  input  logic [NUM_LAYERS-1:0]       layer_opaque,
  input  logic [NUM_LAYERS-1:0]       layer_blink,
  input  logic                        pal_we,
  input  logic [BANK_W-1:0]           pal_bank,
  input  logic [IDX_W-1:0]            pal_addr,
  input  logic [23:0]                 pal_data,
  output logic                        out_valid,
  output logic [7:0]                  VGA_R,
  output logic [7:0]                  VGA_G,
  output logic [7:0]                  VGA_B
);
  localparam int STAGES = 2;
  localparam int CNT_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // ---------------- palette banks ----------------
  logic [NB-1:0][PAL_DEPTH-1:0][23:0] r_pal;

  // Decoding against every legal (bank, entry) pair means out-of-range
  // writes simply match nothing.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_pal <= '0;
    end else if (pal_we) begin
      for (int b = 0; b < NB; b++)
        for (int e = 0; e < PAL_DEPTH; e++)
          if (pal_bank == BANK_W'(b) && pal_addr == IDX_W'(e))
            r_pal[b][e] <= pal_data;
    end
  end

  // ---------------- blink timer ----------------
  logic [CNT_W-1:0] r_frame_cnt;
  logic             r_blink_phase;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b1;
    end else if (frame_start) begin
      if (r_frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
        r_frame_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  // ---------------- stage 1 ----------------
  logic [STAGES:1]             r_vld_pipe;
  logic [NUM_LAYERS-1:0]       r_s1_hit;
  logic [NUM_LAYERS*IDX_W-1:0] r_s1_idx;
  logic [IDX_W-1:0]            r_s1_bg;
  logic                        r_s1_phase;

  // The phase travels with the pixel, so a toggle reaches pixels that enter
  // stage 1 on the cycle after frame_start.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_vld_pipe <= '0;
      r_s1_hit   <= '0;
      r_s1_idx   <= '0;
      r_s1_bg    <= '0;
      r_s1_phase <= 1'b0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:1], pix_valid};
      r_s1_hit   <= layer_hit;
      r_s1_idx   <= layer_idx;
      r_s1_bg    <= bg_idx;
      r_s1_phase <= r_blink_phase;
    end
  end

  // ---------------- stage 2: resolve ----------------
  // Lane NUM_LAYERS is the background: always hit, enabled and opaque, so it
  // is always active and acts as the fallback.
  logic [NB-1:0]             w_hit, w_en, w_opq, w_blk, w_active;
  logic [NB-1:0][IDX_W-1:0]  w_idx;
  logic [NB-1:0][23:0]       w_lane_rgb;
  logic [23:0]               w_rgb;

  assign w_hit = {1'b1, r_s1_hit};
  assign w_en  = {1'b1, layer_en};
  assign w_opq = {1'b1, layer_opaque};
  assign w_blk = {1'b0, layer_blink};
  assign w_idx = {r_s1_bg, r_s1_idx};

  for (genvar i = 0; i < NB; i++) begin : g_lane
    sprite_lane #(.IDX_W(IDX_W), .PAL_DEPTH(PAL_DEPTH)) u_lane (
      .i_hit    (w_hit[i]),
      .i_en     (w_en[i]),
      .i_opaque (w_opq[i]),
      .i_blink  (w_blk[i]),
      .i_phase  (r_s1_phase),
      .i_idx    (w_idx[i]),
      .i_pal    (r_pal[i]),
      .o_active (w_active[i]),
      .o_rgb    (w_lane_rgb[i])
    );
  end

  // Scan from lowest priority up so the lowest-numbered active layer wins.
  always_comb begin
    w_rgb = w_lane_rgb[NUM_LAYERS];
    for (int i = NUM_LAYERS - 1; i >= 0; i--)
      if (w_active[i]) w_rgb = w_lane_rgb[i];
  end

  logic [23:0] r_rgb;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) r_rgb <= '0;
    else       r_rgb <= w_rgb;
  end

  assign out_valid = r_vld_pipe[STAGES];
  assign VGA_R     = r_rgb[23:16];
  assign VGA_G     = r_rgb[15:8];
  assign VGA_B     = r_rgb[7:0];
endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor: table-driven vectors through a cycle-stamped
// scoreboard, plus hand sequences for palette collision, blink and reset.
module tb_sprite_compositor;
  localparam int NL = 4;
  localparam int IW = 4;
  localparam int PD = 8;
  localparam int BF = 2;
  localparam int BW = 3;

  logic            clk = 1'b0;
  logic            Reset = 1'b1;
  logic            frame_start = 1'b0;
  logic            pix_valid = 1'b0;
  logic [NL-1:0]   layer_hit = '0;
  logic [NL*IW-1:0] layer_idx = '0;
  logic [IW-1:0]   bg_idx = '0;
  logic [NL-1:0]   layer_en = '0;
  logic [NL-1:0]   layer_opaque = '0;
  logic [NL-1:0]   layer_blink = '0;
  logic            pal_we = 1'b0;
  logic [BW-1:0]   pal_bank = '0;
  logic [IW-1:0]   pal_addr = '0;
  logic [23:0]     pal_data = '0;
  logic            out_valid;
  logic [7:0]      VGA_R, VGA_G, VGA_B;

  sprite_compositor #(.NUM_LAYERS(NL), .IDX_W(IW), .PAL_DEPTH(PD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .Reset(Reset), .frame_start(frame_start), .pix_valid(pix_valid),
    .layer_hit(layer_hit), .layer_idx(layer_idx), .bg_idx(bg_idx),
    .layer_en(layer_en), .layer_opaque(layer_opaque), .layer_blink(layer_blink),
    .pal_we(pal_we), .pal_bank(pal_bank), .pal_addr(pal_addr), .pal_data(pal_data),
    .out_valid(out_valid), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int          due;
    logic        vld;
    logic [23:0] rgb;
    string       nm;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic        pv;
    logic [3:0]  hit;
    logic [15:0] idx;
    logic [3:0]  bg;
    logic [3:0]  en;
    logic [3:0]  opq;
    logic [3:0]  blk;
    logic [23:0] exp;
  } vec_t;

  // Distinct non-zero preload colour per (bank, entry).
  function automatic logic [23:0] pv(int b, int a);
    return 24'((b * 16 + a + 1) * 66051);
  endfunction

  // Scoreboard: each entry is due two clocks after it was driven.
  always @(negedge clk) begin
    if (sbq.size() > 0 && sbq[0].due <= cyc) begin
      sb_t e;
      e = sbq.pop_front();
      n_vec++;
      if (e.due != cyc || out_valid !== e.vld || {VGA_R, VGA_G, VGA_B} !== e.rgb) begin
        n_err++;
        $display("FAIL %s: got valid=%b rgb=%06h, want valid=%b rgb=%06h (due %0d at %0d)",
                 e.nm, out_valid, {VGA_R, VGA_G, VGA_B}, e.vld, e.rgb, e.due, cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [24:0] act, input logic [24:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %07h, want %07h", nm, act, exp);
    end
  endtask

  task automatic push(input string nm, input logic v, input logic [23:0] rgb);
    sb_t e;
    e.due = cyc + 2; e.vld = v; e.rgb = rgb; e.nm = nm;
    sbq.push_back(e);
  endtask

  task automatic wr(input int b, input int a, input logic [23:0] d);
    pal_we = 1'b1; pal_bank = BW'(b); pal_addr = IW'(a); pal_data = d;
    tick();
    pal_we = 1'b0;
  endtask

  task automatic px(input string nm, input logic [3:0] hit, input logic [15:0] idx,
                    input logic [3:0] bg, input logic [23:0] exp);
    pix_valid = 1'b1; layer_hit = hit; layer_idx = idx; bg_idx = bg;
    push(nm, 1'b1, exp);
    tick();
    pix_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sbq.size() > 0; i++) tick();
    if (sbq.size() > 0) begin
      n_vec++; n_err++;
      $display("FAIL drain: %0d results never arrived", sbq.size());
      sbq.delete();
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  vec_t tbl[15];

  initial begin
    tbl[0]  = '{1'b1, 4'b0011, 16'h0023, 4'h0, 4'hF, 4'h0, 4'h0, pv(0, 3)};
    tbl[1]  = '{1'b1, 4'b0011, 16'h0020, 4'h0, 4'hF, 4'h0, 4'h0, pv(1, 2)};
    tbl[2]  = '{1'b1, 4'b0011, 16'h0000, 4'h5, 4'hF, 4'h0, 4'h0, pv(4, 5)};
    tbl[3]  = '{1'b1, 4'b0000, 16'h0000, 4'h9, 4'hF, 4'h0, 4'h0, 24'h000000};
    tbl[4]  = '{1'b1, 4'b0001, 16'h0000, 4'h0, 4'hF, 4'h1, 4'h0, pv(0, 0)};
    tbl[5]  = '{1'b1, 4'b0001, 16'h0009, 4'h0, 4'hF, 4'h1, 4'h0, 24'h000000};
    tbl[6]  = '{1'b1, 4'b0001, 16'h0009, 4'h2, 4'hF, 4'h0, 4'h0, pv(4, 2)};
    tbl[7]  = '{1'b1, 4'b1111, 16'h4321, 4'h0, 4'hC, 4'h0, 4'h0, pv(2, 3)};
    tbl[8]  = '{1'b1, 4'b1000, 16'h7000, 4'h0, 4'hF, 4'h0, 4'h0, pv(3, 7)};
    tbl[9]  = '{1'b1, 4'b0110, 16'h0500, 4'h0, 4'hF, 4'h0, 4'h0, pv(2, 5)};
    tbl[10] = '{1'b1, 4'b0001, 16'h0004, 4'h0, 4'hF, 4'h0, 4'h1, pv(0, 4)};
    tbl[11] = '{1'b0, 4'b0001, 16'h0001, 4'h0, 4'hF, 4'h0, 4'h0, pv(0, 1)};
    tbl[12] = '{1'b1, 4'b0101, 16'h0608, 4'h0, 4'hF, 4'h0, 4'h0, pv(2, 6)};
    tbl[13] = '{1'b1, 4'b1111, 16'h1111, 4'h7, 4'h0, 4'h0, 4'h0, pv(4, 7)};
    tbl[14] = '{1'b1, 4'b0001, 16'h0000, 4'h1, 4'hE, 4'h1, 4'h0, pv(4, 1)};

    // ---- reset state ----
    @(posedge clk); @(posedge clk); #1;
    chk("reset_out", {out_valid, VGA_R, VGA_G, VGA_B}, 25'h0);
    Reset = 1'b0;
    tick();
    chk("post_reset_valid0", {24'h0, out_valid}, 25'h0);
    tick();
    chk("post_reset_valid1", {24'h0, out_valid}, 25'h0);

    // ---- preload all banks ----
    for (int b = 0; b <= NL; b++)
      for (int a = 0; a < PD; a++)
        wr(b, a, pv(b, a));

    // ---- table: config lags the pixel by one cycle so it lines up with stage 2 ----
    for (int k = 0; k <= 15; k++) begin
      int kc;
      if (k < 15) begin
        pix_valid = tbl[k].pv; layer_hit = tbl[k].hit;
        layer_idx = tbl[k].idx; bg_idx = tbl[k].bg;
        push($sformatf("vec%0d", k), tbl[k].pv, tbl[k].exp);
      end else begin
        pix_valid = 1'b0; layer_hit = '0;
      end
      kc = (k == 0) ? 0 : k - 1;
      layer_en = tbl[kc].en; layer_opaque = tbl[kc].opq; layer_blink = tbl[kc].blk;
      tick();
    end
    drain();

    // ---- literal priority / transparency / opaque cases ----
    layer_en = 4'hF; layer_opaque = 4'h0; layer_blink = 4'h0;
    wr(0, 3, 24'hFF0000); wr(1, 2, 24'h00FF00); wr(NL, 5, 24'h0000FF); wr(0, 0, 24'h123456);
    px("prio", 4'b0011, 16'h0023, 4'h0, 24'hFF0000);
    px("transp1", 4'b0011, 16'h0020, 4'h0, 24'h00FF00);
    px("transp_bg", 4'b0011, 16'h0000, 4'h5, 24'h0000FF);
    drain();
    layer_opaque = 4'h1;
    px("opaque0", 4'b0001, 16'h0000, 4'h0, 24'h123456);
    px("opaque_oob", 4'b0001, 16'h0009, 4'h0, 24'h000000);
    drain();
    layer_opaque = 4'h0;

    // ---- write/read collision ----
    wr(0, 3, 24'h111111);
    pix_valid = 1'b1; layer_hit = 4'b0001; layer_idx = 16'h0003; bg_idx = 4'h0;
    push("coll_old", 1'b1, 24'h111111);
    tick();
    pal_we = 1'b1; pal_bank = 3'd0; pal_addr = 4'd3; pal_data = 24'hABCDEF;
    push("coll_new", 1'b1, 24'hABCDEF);
    tick();
    pal_we = 1'b0; pix_valid = 1'b0;
    drain();

    // ---- ignored writes: bank out of range, entry out of range ----
    wr(NL + 1, 3, 24'h777777);
    wr(0, 9, 24'h777777);
    px("bank0_3", 4'b0001, 16'h0003, 4'h0, 24'hABCDEF);
    px("bank1_3", 4'b0010, 16'h0030, 4'h0, pv(1, 3));
    px("bank2_3", 4'b0100, 16'h0300, 4'h0, pv(2, 3));
    px("bank3_3", 4'b1000, 16'h3000, 4'h0, pv(3, 3));
    px("bank4_3", 4'b0000, 16'h0000, 4'h3, pv(4, 3));
    px("bank0_1", 4'b0001, 16'h0001, 4'h0, pv(0, 1));
    drain();

    // ---- blink: hidden after 2nd frame_start, visible again after 4th ----
    layer_blink = 4'h1;
    for (int f = 1; f <= 4; f++) begin
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
      px($sformatf("blink_f%0d", f), 4'b0001, 16'h0004, 4'h2,
         (f == 2 || f == 3) ? pv(4, 2) : pv(0, 4));
      tick(); tick();
    end
    drain();
    layer_blink = 4'h0;

    // ---- reset mid-stream ----
    pix_valid = 1'b1; layer_hit = 4'b0001; layer_idx = 16'h0004; bg_idx = 4'h0;
    tick(); tick();
    chk("pre_reset_valid", {24'h0, out_valid}, 25'h1);
    Reset = 1'b1;
    pal_we = 1'b1; pal_bank = 3'd0; pal_addr = 4'd4; pal_data = 24'hFFFFFF;
    frame_start = 1'b1;
    #1;
    chk("reset_async", {out_valid, VGA_R, VGA_G, VGA_B}, 25'h0);
    tick(); tick();
    Reset = 1'b0; pal_we = 1'b0; frame_start = 1'b0; pix_valid = 1'b0;
    tick();
    chk("rst_rel_valid0", {24'h0, out_valid}, 25'h0);
    tick();
    chk("rst_rel_valid1", {24'h0, out_valid}, 25'h0);
    px("clr_bank0_4", 4'b0001, 16'h0004, 4'h0, 24'h000000);
    px("clr_bank4_5", 4'b0000, 16'h0000, 4'h5, 24'h000000);
    px("clr_bank1_2", 4'b0010, 16'h0020, 4'h0, 24'h000000);
    px("clr_bank0_0", 4'b0001, 16'h0000, 4'h0, 24'h000000);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
